// File: rtl/mouse_ev_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mouse_ev_pkg
// Description : Event encodings, queue payload and FSM states for the mouse
//               event queue.
// Revision    : 1.0 - initial release
// ============================================================================
package mouse_ev_pkg;

    // Coordinate width carried in a queued event; matches $clog2(10) bins.
    localparam int C_POS_BITS = 4;

    typedef enum logic [1:0] {
        EV_MOVE    = 2'b00,
        EV_PRESS   = 2'b01,
        EV_RELEASE = 2'b10,
        EV_DOUBLE  = 2'b11
    } ev_type_t;

    typedef enum logic [1:0] {
        BTN_LEFT   = 2'd0,
        BTN_RIGHT  = 2'd1,
        BTN_MIDDLE = 2'd2,
        BTN_NONE   = 2'd3
    } btn_id_t;

    typedef struct packed {
        ev_type_t              ev_type;
        btn_id_t               button;
        logic [C_POS_BITS-1:0] x;
        logic [C_POS_BITS-1:0] y;
    } mouse_event_t;

    localparam int C_EVENT_BITS = $bits(mouse_event_t);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } fsm_state_t;

endpackage
`default_nettype wire

// File: rtl/mouse_event_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : mouse_event_queue_if
// Description : Valid/ready event stream from the queue to its consumer.
// Revision    : 1.0 - initial release
// ============================================================================
interface mouse_event_queue_if #(
    parameter int COUNT_BITS = 4
);
    import mouse_ev_pkg::*;

    logic                  ev_valid;
    logic                  ev_ready;
    ev_type_t              ev_type;
    btn_id_t               ev_button;
    logic [C_POS_BITS-1:0] ev_x;
    logic [C_POS_BITS-1:0] ev_y;
    logic [COUNT_BITS-1:0] ev_count;

    modport master (
        output ev_valid, ev_type, ev_button, ev_x, ev_y, ev_count,
        input  ev_ready
    );

    modport slave (
        input  ev_valid, ev_type, ev_button, ev_x, ev_y, ev_count,
        output ev_ready
    );

endinterface
`default_nettype wire

// File: rtl/ev_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ev_fifo
// Description : Synchronous first-word fall-through FIFO; a push into a full
//               FIFO is still accepted when a pop happens in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module ev_fifo #(
    parameter  int DEPTH     = 8,
    parameter  int DATA_BITS = 12,
    localparam int C_AW      = $clog2(DEPTH)
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic                 push,
    input  wire logic [DATA_BITS-1:0] din,
    output logic                      full,
    input  wire logic                 pop,
    output logic                      empty,
    output logic      [DATA_BITS-1:0] dout,
    output logic      [C_AW:0]        count
);

    logic [DATA_BITS-1:0] r_mem [DEPTH];
    logic [C_AW-1:0]      r_rd_ptr;
    logic [C_AW-1:0]      r_wr_ptr;
    logic [C_AW:0]        r_count;
    logic                 w_do_pop;
    logic                 w_do_push;

    assign empty     = (r_count == '0);
    assign full      = (r_count == (C_AW+1)'(DEPTH));
    assign count     = r_count;
    assign dout      = r_mem[r_rd_ptr];
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // When full, the write slot is the head being popped; dout already
    // presented the old value this cycle.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= din;
    end

endmodule
`default_nettype wire

// File: rtl/mouse_event_queue.sv
`default_nettype none
// ============================================================================
// Module      : mouse_event_queue
// Description : Turns mouse button/position changes into PRESS, RELEASE,
//               DOUBLE and MOVE events and queues them for the consumer.
// Revision    : 1.0 - initial release
// ============================================================================
module mouse_event_queue
    import mouse_ev_pkg::*;
#(
    parameter  int WIDTH      = 10,
    parameter  int HEIGHT     = 10,
    parameter  int FIFO_DEPTH = 8,
    parameter  int DBL_CYCLES = 15000000,
    localparam int UPPER_BITS = $clog2((WIDTH > HEIGHT) ? WIDTH : HEIGHT)
) (
    input  wire logic                  CLOCK_50,
    input  wire logic                  reset,
    input  wire logic                  button_left,
    input  wire logic                  button_right,
    input  wire logic                  button_middle,
    input  wire logic [UPPER_BITS-1:0] bin_x,
    input  wire logic [UPPER_BITS-1:0] bin_y,
    mouse_event_queue_if.master        ev,
    output logic                       overflow,
    input  wire logic                  ovf_clear
);

    localparam int C_TMR_BITS = $clog2(DBL_CYCLES + 1);
    localparam int C_CNT_BITS = $clog2(FIFO_DEPTH) + 1;

    // Button vectors are indexed by slot: 0 left, 1 right, 2 middle.
    logic [2:0]            r_in_btn,  r_ref_btn,  r_snap_btn;
    logic [UPPER_BITS-1:0] r_in_x,    r_ref_x,    r_snap_x;
    logic [UPPER_BITS-1:0] r_in_y,    r_ref_y,    r_snap_y;
    fsm_state_t            r_state,   w_state_nxt;
    logic [1:0]            r_slot,    w_slot_nxt;
    logic [C_TMR_BITS-1:0] r_dbl_tmr;
    logic                  r_overflow;
    logic                  w_snap_load;
    logic                  w_push;
    mouse_event_t          w_event;
    mouse_event_t          w_head;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic                  w_pop;
    logic [C_CNT_BITS-1:0] w_fifo_count;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_in_btn <= '0;
            r_in_x   <= '0;
            r_in_y   <= '0;
        end else begin
            r_in_btn <= {button_middle, button_right, button_left};
            r_in_x   <= bin_x;
            r_in_y   <= bin_y;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_slot  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_slot  <= w_slot_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_slot_nxt      = r_slot;
        w_snap_load     = 1'b0;
        w_push          = 1'b0;
        w_event.ev_type = EV_MOVE;
        w_event.button  = BTN_NONE;
        w_event.x       = C_POS_BITS'(r_snap_x);
        w_event.y       = C_POS_BITS'(r_snap_y);
        case (r_state)
            ST_IDLE: begin
                if ({r_in_btn, r_in_x, r_in_y} != {r_ref_btn, r_ref_x, r_ref_y}) begin
                    w_snap_load = 1'b1;
                    w_slot_nxt  = 2'd0;
                    w_state_nxt = ST_EMIT;
                end
            end
            ST_EMIT: begin
                w_slot_nxt = r_slot + 2'd1;
                if (r_slot == 2'd3) begin
                    w_state_nxt = ST_IDLE;
                    w_push      = (r_snap_x != r_ref_x) || (r_snap_y != r_ref_y);
                end else if (r_snap_btn[r_slot] != r_ref_btn[r_slot]) begin
                    w_push         = 1'b1;
                    w_event.button = btn_id_t'(r_slot);
                    if (!r_snap_btn[r_slot])
                        w_event.ev_type = EV_RELEASE;
                    else if ((r_slot == 2'd0) && (r_dbl_tmr != '0))
                        w_event.ev_type = EV_DOUBLE;
                    else
                        w_event.ev_type = EV_PRESS;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // The reference tracks what has been reported, even if the FIFO dropped it.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_ref_btn  <= '0;
            r_ref_x    <= '0;
            r_ref_y    <= '0;
            r_snap_btn <= '0;
            r_snap_x   <= '0;
            r_snap_y   <= '0;
        end else begin
            if (w_snap_load) begin
                r_snap_btn <= r_in_btn;
                r_snap_x   <= r_in_x;
                r_snap_y   <= r_in_y;
            end
            if (w_push) begin
                if (r_slot == 2'd3) begin
                    r_ref_x <= r_snap_x;
                    r_ref_y <= r_snap_y;
                end else begin
                    r_ref_btn[r_slot] <= r_snap_btn[r_slot];
                end
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_dbl_tmr <= '0;
        end else if (w_push && (r_slot == 2'd0) && r_snap_btn[0]) begin
            r_dbl_tmr <= (r_dbl_tmr == '0) ? C_TMR_BITS'(DBL_CYCLES) : '0;
        end else if (r_dbl_tmr != '0) begin
            r_dbl_tmr <= r_dbl_tmr - 1'b1;
        end
    end

    assign w_pop = !w_fifo_empty && ev.ev_ready;

    always_ff @(posedge CLOCK_50) begin
        if (reset)
            r_overflow <= 1'b0;
        else if (w_push && w_fifo_full && !w_pop)
            r_overflow <= 1'b1;
        else if (ovf_clear)
            r_overflow <= 1'b0;
    end

    ev_fifo #(
        .DEPTH     (FIFO_DEPTH),
        .DATA_BITS (C_EVENT_BITS)
    ) u_fifo (
        .clk   (CLOCK_50),
        .rst   (reset),
        .push  (w_push),
        .din   (w_event),
        .full  (w_fifo_full),
        .pop   (w_pop),
        .empty (w_fifo_empty),
        .dout  (w_head),
        .count (w_fifo_count)
    );

    assign ev.ev_valid  = !w_fifo_empty;
    assign ev.ev_type   = w_head.ev_type;
    assign ev.ev_button = w_head.button;
    assign ev.ev_x      = w_head.x;
    assign ev.ev_y      = w_head.y;
    assign ev.ev_count  = w_fifo_count;
    assign overflow     = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_mouse_event_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_mouse_event_queue
// Description : Directed and randomized bench for mouse_event_queue against a
//               snapshot-level event model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mouse_event_queue;
    import mouse_ev_pkg::*;

    localparam int DBL   = 100;
    localparam int DEPTH = 8;

    typedef struct packed {
        logic [2:0] btn;
        logic [3:0] x;
        logic [3:0] y;
    } mstate_t;

    typedef struct {
        int unsigned  edge_n;
        mouse_event_t ev;
    } pend_t;

    logic       CLOCK_50 = 1'b0;
    logic       reset = 1'b1;
    logic       button_left = 1'b0, button_right = 1'b0, button_middle = 1'b0;
    logic [3:0] bin_x = 4'd3, bin_y = 4'd4;
    logic       overflow;
    logic       ovf_clear = 1'b0;

    int checks = 0;
    int failures = 0;

    mouse_event_queue_if #(.COUNT_BITS(4)) ev_if ();

    mouse_event_queue #(
        .WIDTH      (10),
        .HEIGHT     (10),
        .FIFO_DEPTH (DEPTH),
        .DBL_CYCLES (DBL)
    ) dut (
        .CLOCK_50      (CLOCK_50),
        .reset         (reset),
        .button_left   (button_left),
        .button_right  (button_right),
        .button_middle (button_middle),
        .bin_x         (bin_x),
        .bin_y         (bin_y),
        .ev            (ev_if),
        .overflow      (overflow),
        .ovf_clear     (ovf_clear)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    // Model: each accepted snapshot expands at once into its event list, each
    // tagged with the clock edge at which the queue receives it.
    mouse_event_t mq[$];
    pend_t        pend[$];
    mstate_t      m_inq, m_ref, m_cur;
    logic         m_ovf, m_armed, m_live = 1'b0, m_drop;
    int unsigned  m_arm_edge, m_next_cmp, cyc = 0;
    mouse_event_t m_e;

    always @(posedge CLOCK_50) begin
        m_cur = '{btn: {button_middle, button_right, button_left}, x: bin_x, y: bin_y};
        if (reset) begin
            mq.delete();
            pend.delete();
            m_inq = '0; m_ref = '0; m_ovf = 1'b0; m_armed = 1'b0;
            m_next_cmp = 0; m_live = 1'b1;
        end else begin
            m_drop = 1'b0;
            if (mq.size() != 0 && ev_if.ev_ready) void'(mq.pop_front());
            if (pend.size() != 0 && pend[0].edge_n == cyc) begin
                if (mq.size() < DEPTH) mq.push_back(pend[0].ev);
                else m_drop = 1'b1;
                void'(pend.pop_front());
            end
            if (m_drop) m_ovf = 1'b1;
            else if (ovf_clear) m_ovf = 1'b0;
            if (cyc >= m_next_cmp && m_inq != m_ref) begin
                for (int i = 0; i < 3; i++) begin
                    if (m_inq.btn[i] != m_ref.btn[i]) begin
                        m_e.ev_type = m_inq.btn[i] ? EV_PRESS : EV_RELEASE;
                        m_e.button  = btn_id_t'(2'(i));
                        m_e.x = m_inq.x; m_e.y = m_inq.y;
                        if (i == 0 && m_inq.btn[0]) begin
                            if (m_armed && (cyc + 1 - m_arm_edge) <= DBL) begin
                                m_e.ev_type = EV_DOUBLE;
                                m_armed = 1'b0;
                            end else begin
                                m_armed = 1'b1;
                                m_arm_edge = cyc + 1;
                            end
                        end
                        pend.push_back('{edge_n: cyc + 1 + i, ev: m_e});
                    end
                end
                if (m_inq.x != m_ref.x || m_inq.y != m_ref.y)
                    pend.push_back('{edge_n: cyc + 4,
                                     ev: '{ev_type: EV_MOVE, button: BTN_NONE, x: m_inq.x, y: m_inq.y}});
                m_ref = m_inq;
                m_next_cmp = cyc + 5;
            end
            m_inq = m_cur;
        end
        cyc++;
    end

    mouse_event_t log_q[$];
    mouse_event_t head_act;

    always @(negedge CLOCK_50) begin
        head_act = '{ev_type: ev_if.ev_type, button: ev_if.ev_button, x: ev_if.ev_x, y: ev_if.ev_y};
        if (m_live) begin
            check("valid", 32'(ev_if.ev_valid), 32'(mq.size() != 0));
            check("overflow", 32'(overflow), 32'(m_ovf));
            check("count", 32'(ev_if.ev_count), 32'(mq.size()));
            if (ev_if.ev_valid && mq.size() != 0)
                check("head", 32'(head_act), 32'(mq[0]));
        end
        if (!reset && ev_if.ev_valid && ev_if.ev_ready) log_q.push_back(head_act);
    end

    initial begin
        ev_if.ev_ready = 1'b0;
        tick(3);
        check("rst_valid", 32'(ev_if.ev_valid), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_count", 32'(ev_if.ev_count), 32'd0);
        reset = 1'b0;

        // 1: initial bin is reported as MOVE and drained, then a left press.
        ev_if.ev_ready = 1'b1;
        tick(12);
        ev_if.ev_ready = 1'b0;
        button_left = 1'b1;
        tick(2);
        check("t1_early", 32'(ev_if.ev_valid), 32'd0);
        tick(1);
        check("t1_valid", 32'(ev_if.ev_valid), 32'd1);
        check("t1_head", 32'(head_act_now()), 32'({EV_PRESS, BTN_LEFT, 4'd3, 4'd4}));
        ev_if.ev_ready = 1'b1;
        tick(1);
        check("t1_popped", 32'(ev_if.ev_valid), 32'd0);
        tick(10);
        check("t1_quiet", 32'(ev_if.ev_valid), 32'd0);

        // 2: right press and x move in the same cycle.
        ev_if.ev_ready = 1'b0;
        button_right = 1'b1; bin_x = 4'd4;
        tick(4);
        check("t2_press", 32'(head_act_now()), 32'({EV_PRESS, BTN_RIGHT, 4'd4, 4'd4}));
        ev_if.ev_ready = 1'b1;
        tick(1);
        check("t2_gap", 32'(ev_if.ev_valid), 32'd0);
        tick(1);
        check("t2_move_v", 32'(ev_if.ev_valid), 32'd1);
        check("t2_move", 32'(head_act_now()), 32'({EV_MOVE, BTN_NONE, 4'd4, 4'd4}));
        tick(9);
        check("t2_quiet", 32'(ev_if.ev_valid), 32'd0);

        // 3: double-click window.
        button_left = 1'b0; button_right = 1'b0;
        tick(150);
        log_q.delete();
        button_left = 1'b1; tick(10);
        button_left = 1'b0; tick(10);
        button_left = 1'b1; tick(10);
        check("t3a_n", 32'(log_q.size()), 32'd3);
        if (log_q.size() >= 3) begin
            check("t3a_0", 32'({log_q[0].ev_type, log_q[0].button}), 32'({EV_PRESS, BTN_LEFT}));
            check("t3a_1", 32'({log_q[1].ev_type, log_q[1].button}), 32'({EV_RELEASE, BTN_LEFT}));
            check("t3a_2", 32'({log_q[2].ev_type, log_q[2].button}), 32'({EV_DOUBLE, BTN_LEFT}));
        end
        log_q.delete();
        button_left = 1'b0; tick(160);
        button_left = 1'b1; tick(10);
        check("t3b_n", 32'(log_q.size()), 32'd2);
        if (log_q.size() >= 2) begin
            check("t3b_0", 32'(log_q[0].ev_type), 32'(EV_RELEASE));
            check("t3b_1", 32'(log_q[1].ev_type), 32'(EV_PRESS));
        end

        // 4: ten moves into a stalled queue.
        ev_if.ev_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bin_x = 4'((i + 5) % 10);
            tick(6);
        end
        tick(6);
        check("t4_ovf", 32'(overflow), 32'd1);
        check("t4_count", 32'(ev_if.ev_count), 32'd8);
        log_q.delete();
        ev_if.ev_ready = 1'b1;
        tick(12);
        ev_if.ev_ready = 1'b0;
        check("t4_drained", 32'(log_q.size()), 32'd8);
        for (int i = 0; i < 8; i++)
            if (log_q.size() > i)
                check("t4_order", 32'({log_q[i].ev_type, log_q[i].x}), 32'({EV_MOVE, 4'((i + 5) % 10)}));
        ovf_clear = 1'b1; tick(1); ovf_clear = 1'b0;
        check("t4_clear", 32'(overflow), 32'd0);
        for (int i = 0; i < 8; i++) begin
            bin_x = 4'(i);
            tick(6);
        end
        bin_x = 4'd9; ovf_clear = 1'b1;
        tick(6);
        ovf_clear = 1'b0;
        check("t4_set_wins", 32'(overflow), 32'd1);

        // 5: push and pop on the same edge while full.
        ovf_clear = 1'b1; tick(1); ovf_clear = 1'b0;
        bin_x = 4'd3;
        tick(5);
        ev_if.ev_ready = 1'b1;
        tick(1);
        ev_if.ev_ready = 1'b0;
        check("t5_count", 32'(ev_if.ev_count), 32'd8);
        check("t5_ovf", 32'(overflow), 32'd0);
        log_q.delete();
        ev_if.ev_ready = 1'b1;
        tick(12);
        check("t5_n", 32'(log_q.size()), 32'd8);
        if (log_q.size() >= 8) begin
            check("t5_first", 32'(log_q[0].x), 32'd1);
            check("t5_last", 32'(log_q[7].x), 32'd3);
        end

        // 6: reset in slot 1 of a left+right+move snapshot.
        button_left = 1'b0; bin_x = 4'd0; bin_y = 4'd0;
        tick(10);
        button_left = 1'b1; button_right = 1'b1; bin_x = 4'd2; bin_y = 4'd5;
        tick(3);
        reset = 1'b1;
        tick(1);
        check("t6_flush", 32'(ev_if.ev_valid), 32'd0);
        log_q.delete();
        tick(1);
        reset = 1'b0;
        tick(12);
        check("t6_n", 32'(log_q.size()), 32'd3);
        if (log_q.size() >= 3) begin
            check("t6_0", 32'(log_q[0]), 32'({EV_PRESS, BTN_LEFT, 4'd2, 4'd5}));
            check("t6_1", 32'(log_q[1]), 32'({EV_PRESS, BTN_RIGHT, 4'd2, 4'd5}));
            check("t6_2", 32'(log_q[2]), 32'({EV_MOVE, BTN_NONE, 4'd2, 4'd5}));
        end

        // Randomized traffic; the per-cycle compare carries the checking.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom % 8 == 0) begin
                case ($urandom % 3)
                    0: button_left = ~button_left;
                    1: button_right = ~button_right;
                    default: button_middle = ~button_middle;
                endcase
            end
            if ($urandom % 6 == 0) bin_x = 4'($urandom_range(0, 9));
            if ($urandom % 9 == 0) bin_y = 4'($urandom_range(0, 9));
            ev_if.ev_ready = ((n / 64) % 3 != 0) ? ($urandom % 4 != 0) : 1'b0;
            ovf_clear = ($urandom % 20 == 0);
            reset = ($urandom % 700 == 0);
            tick(1);
        end
        reset = 1'b0; ovf_clear = 1'b0; ev_if.ev_ready = 1'b1;
        tick(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    function automatic mouse_event_t head_act_now();
        return '{ev_type: ev_if.ev_type, button: ev_if.ev_button, x: ev_if.ev_x, y: ev_if.ev_y};
    endfunction

endmodule
`default_nettype wire
